ccff_loader: RTL and testbench
==============================

Name: ccff_loader

Overview:
Transmitter end of the FPGA configuration chain (CCFF) on the Caravel user project side.
- Load mode: fetches bitstream words over a valid/ready interface, serializes them MSB-first onto ccff_head, and issues one shift enable per bit.
- Chain-test mode: shifts a single-'1' marker and measures the cycles until it emerges on ccff_tail, which proves chain length and integrity before programming.
- Sits between the SoC-side bitstream source and the fabric's ccff_head, ccff_tail and prog-clock gate.

Parameters:
- BITSTREAM_SIZE, 29696: number of flops in the configuration chain; also the number of bits shifted per load.
- WORD_W, 32: width of the bitstream input word.
- TAIL_MARGIN, 16: extra shifts allowed past BITSTREAM_SIZE before chain test declares timeout.
- CNT_W, $clog2(BITSTREAM_SIZE+TAIL_MARGIN+1): bit-counter width (derived, not overridden).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge
- prog_reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE
- test_mode  in  1  sampled with start: 1 = chain test, 0 = load
- word_data  in  WORD_W  bitstream word; MSB shifted first
- word_valid  in  1  word_data valid
- word_ready  out  1  loader accepts word this cycle
- ccff_head  out  1  registered serial data into chain
- ccff_shift_en  out  1  fabric chain shifts on the next prog_clk edge when high
- ccff_tail  in  1  chain output
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at completion
- error  out  1  sticky until next start: chain test failed
- chain_len  out  CNT_W  shift count at which the marker was seen; 0 if never seen

Behaviour:
- Reset: state IDLE; word_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0, chain_len=0; counters cleared.
- Reset mid-operation aborts immediately; no partial-word flush.
- States: IDLE, LOAD, SHIFT, TEST_SHIFT, FINISH.
- IDLE, start=1:
  - clear error and chain_len; bit_cnt=0.
  - test_mode=0 -> LOAD; test_mode=1 -> TEST_SHIFT.
  - start while busy is ignored.
- LOAD:
  - word_ready=1, ccff_shift_en=0.
  - valid&ready: capture word into shift register, set bits_left = min(WORD_W, BITSTREAM_SIZE-bit_cnt), go to SHIFT.
  - word_valid=0: stall indefinitely; no shift is issued.
- SHIFT:
  - each cycle: ccff_head=shreg MSB, ccff_shift_en=1, shreg<<=1, bit_cnt++, bits_left--.
  - on last bit of word: bit_cnt==BITSTREAM_SIZE -> FINISH; else -> LOAD.
  - throughput: WORD_W bits per WORD_W+1 cycles.
  - final partial word: only the top (BITSTREAM_SIZE mod WORD_W) bits are shifted; low bits discarded.
- TEST_SHIFT:
  - ccff_shift_en=1 every cycle; ccff_head=1 on the first shift (bit_cnt==0), 0 thereafter; bit_cnt++ per shift.
  - ccff_tail is sampled each cycle after at least one shift, and the value is attributed to the count of shifts already completed (k).
  - tail=1 with k==BITSTREAM_SIZE: pass; chain_len=k; -> FINISH.
  - tail=1 with k!=BITSTREAM_SIZE: error=1; chain_len=k; -> FINISH.
  - k reaches BITSTREAM_SIZE+TAIL_MARGIN with tail never 1: error=1; chain_len=0; -> FINISH.
- FINISH:
  - ccff_shift_en=0, ccff_head=0; done=1 for one cycle; -> IDLE.
- ccff_head is held at 0 whenever ccff_shift_en=0.
- Ready/valid rule: data is transferred only on valid&ready in the same cycle.

Decomposition:
- Shared package ccff_pkg: state enum, default BITSTREAM_SIZE, and the count-width function.
- One natural sub-module: ccff_serializer (WORD_W shift register plus bits_left counter, load/shift/empty), instantiated by ccff_loader.
- FSM and chain-test logic stay in ccff_loader.

Test Plan:
- Reset values: prog_reset=1 -> all outputs 0; release, no start -> state stays IDLE, busy=0 for 100 cycles.
- Chain-test pass: bench model is a 29696-flop shift register; start, test_mode=1 -> done after ~29697 cycles, error=0, chain_len=29696, exactly one '1' driven on ccff_head.
- Chain-test faults: model length 29690 -> error=1, chain_len=29690; tail stuck 0 -> error=1, chain_len=0, done at shift 29712.
- Load with partial word (BITSTREAM_SIZE=40, WORD_W=32): words 0xA5A5_F00F, 0xC3xx_xxxx -> serial stream = 32 bits of word 0 then 0xC3 MSB-first, 40 shift_en pulses total, done=1, model contents match.
- Stall and ignored start: hold word_valid=0 for 10 cycles in LOAD -> ccff_shift_en=0 throughout, no bit lost; start pulse while busy -> no restart, bit count unchanged.
- Reset mid-SHIFT at bit 17 -> next cycle ccff_shift_en=0, busy=0; new start -> clean load from bit 0.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the CCFF configuration-chain loader.
package ccff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_TEST_SHIFT,
    ST_FINISH
  } ccff_state_e;

  localparam int unsigned DEFAULT_BITSTREAM_SIZE = 29696;

  // Width needed to hold every value from 0 to max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/ccff_serializer.sv
// Word-wide shift register with a bits-left counter; MSB leaves first.
module ccff_serializer #(
  parameter int unsigned  WORD_W = 32,
  localparam int unsigned LEFT_W = $clog2(WORD_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [LEFT_W-1:0] nbits_i,
  output logic              msb_o,
  output logic              last_o,
  output logic              empty_o
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [LEFT_W-1:0] left_q, left_d;

  always_comb begin
    shreg_d = shreg_q;
    left_d  = left_q;
    if (load_i) begin
      shreg_d = word_i;
      left_d  = nbits_i;
    end else if (shift_i && (left_q != '0)) begin
      shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
      left_d  = left_q - LEFT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      left_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      left_q  <= left_d;
    end
  end

  assign msb_o   = shreg_q[WORD_W-1];
  assign last_o  = (left_q == LEFT_W'(1));
  assign empty_o = (left_q == '0);

endmodule

// File: rtl/ccff_loader.sv
// CCFF chain transmitter: serializes bitstream words onto ccff_head, or
// runs a single-marker chain test that measures the chain length.
//   state      | meaning
//   IDLE       | waiting for start
//   LOAD       | word_ready high, waiting for the next bitstream word
//   SHIFT      | one chain shift per cycle from the serializer
//   TEST_SHIFT | shifting the marker, watching ccff_tail
//   FINISH     | one-cycle done pulse
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int unsigned  BITSTREAM_SIZE = DEFAULT_BITSTREAM_SIZE,
  parameter int unsigned  WORD_W         = 32,
  parameter int unsigned  TAIL_MARGIN    = 16,
  localparam int unsigned CNT_W          = cnt_width(BITSTREAM_SIZE + TAIL_MARGIN)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              test_mode,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  chain_len
);

  localparam int unsigned      LEFT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] SIZE_C    = CNT_W'(BITSTREAM_SIZE);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(BITSTREAM_SIZE + TAIL_MARGIN);
  localparam logic [CNT_W-1:0] WORD_C    = CNT_W'(WORD_W);

  ccff_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] chain_len_q, chain_len_d;
  logic             error_q, error_d;

  logic              ser_load, ser_shift, ser_msb, ser_last, ser_empty;
  logic [CNT_W-1:0]  remaining;
  logic [LEFT_W-1:0] nbits;

  // The final word of the bitstream may be only partially shifted.
  assign remaining = SIZE_C - bit_cnt_q;
  assign nbits     = (remaining >= WORD_C) ? LEFT_W'(WORD_W) : LEFT_W'(remaining);

  ccff_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk_i   (prog_clk),
    .rst_i   (prog_reset),
    .load_i  (ser_load),
    .shift_i (ser_shift),
    .word_i  (word_data),
    .nbits_i (nbits),
    .msb_o   (ser_msb),
    .last_o  (ser_last),
    .empty_o (ser_empty)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    chain_len_d   = chain_len_q;
    error_d       = error_q;
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    word_ready    = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    done          = 1'b0;
    busy          = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d     = 1'b0;
          chain_len_d = '0;
          bit_cnt_d   = '0;
          state_d     = test_mode ? ST_TEST_SHIFT : ST_LOAD;
        end
      end
      ST_LOAD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_empty) begin
          state_d = (bit_cnt_q == SIZE_C) ? ST_FINISH : ST_LOAD;
        end else begin
          ccff_shift_en = 1'b1;
          ccff_head     = ser_msb;
          ser_shift     = 1'b1;
          bit_cnt_d     = bit_cnt_q + CNT_W'(1);
          if (ser_last) state_d = (bit_cnt_d == SIZE_C) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_TEST_SHIFT: begin
        ccff_shift_en = 1'b1;
        ccff_head     = (bit_cnt_q == '0);
        bit_cnt_d     = bit_cnt_q + CNT_W'(1);
        // bit_cnt_q is the number of shifts already completed this cycle.
        if ((bit_cnt_q != '0) && ccff_tail) begin
          chain_len_d = bit_cnt_q;
          error_d     = (bit_cnt_q != SIZE_C);
          state_d     = ST_FINISH;
        end else if (bit_cnt_q == TIMEOUT_C) begin
          chain_len_d = '0;
          error_d     = 1'b1;
          state_d     = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      chain_len_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      chain_len_q <= chain_len_d;
      error_q     <= error_d;
    end
  end

  assign error     = error_q;
  assign chain_len = chain_len_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench: three full-size loaders for chain tests, one 40-bit loader for load tests.
module tb_ccff_loader;

  localparam int BIG_N   = 29696;
  localparam int SHORT_N = 29690;
  localparam int SMALL_N = 40;
  localparam int BW      = $clog2(BIG_N + 16 + 1);
  localparam int SW      = $clog2(SMALL_N + 16 + 1);
  localparam logic [31:0] WORD0 = 32'hA5A5_F00F;
  localparam logic [31:0] WORD1 = 32'hC35A_1234;
  localparam logic [39:0] EXP_SMALL = 40'hA5A5_F00F_C3;

  logic prog_clk = 1'b0;
  logic prog_reset = 1'b1;
  always #5 prog_clk = ~prog_clk;

  int n_vec = 0;
  int n_err = 0;

  // Full-size loaders sharing control: p = good chain, q = short chain, t = tail stuck 0
  logic          b_start = 1'b0, b_test_mode = 1'b1;
  logic [31:0]   b_word = '0;
  logic          p_ready, p_head, p_sen, p_busy, p_done, p_error;
  logic          q_ready, q_head, q_sen, q_busy, q_done, q_error;
  logic          t_ready, t_head, t_sen, t_busy, t_done, t_error;
  logic [BW-1:0] p_len, q_len, t_len;
  logic [BIG_N-1:0]   p_chain;
  logic [SHORT_N-1:0] q_chain;
  int            p_ones;

  ccff_loader u_pass (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(b_start), .test_mode(b_test_mode),
    .word_data(b_word), .word_valid(1'b0), .word_ready(p_ready), .ccff_head(p_head),
    .ccff_shift_en(p_sen), .ccff_tail(p_chain[BIG_N-1]), .busy(p_busy), .done(p_done),
    .error(p_error), .chain_len(p_len));

  ccff_loader u_short (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(b_start), .test_mode(b_test_mode),
    .word_data(b_word), .word_valid(1'b0), .word_ready(q_ready), .ccff_head(q_head),
    .ccff_shift_en(q_sen), .ccff_tail(q_chain[SHORT_N-1]), .busy(q_busy), .done(q_done),
    .error(q_error), .chain_len(q_len));

  ccff_loader u_stuck (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(b_start), .test_mode(b_test_mode),
    .word_data(b_word), .word_valid(1'b0), .word_ready(t_ready), .ccff_head(t_head),
    .ccff_shift_en(t_sen), .ccff_tail(1'b0), .busy(t_busy), .done(t_done),
    .error(t_error), .chain_len(t_len));

  // Small loader for the load path
  logic          s_start = 1'b0, s_test_mode = 1'b0, s_valid = 1'b0;
  logic [31:0]   s_word = '0;
  logic          s_ready, s_head, s_sen, s_busy, s_done, s_error;
  logic [SW-1:0] s_len;
  logic [SMALL_N-1:0] s_chain;
  int            s_shifts;

  ccff_loader #(.BITSTREAM_SIZE(SMALL_N)) u_small (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(s_start), .test_mode(s_test_mode),
    .word_data(s_word), .word_valid(s_valid), .word_ready(s_ready), .ccff_head(s_head),
    .ccff_shift_en(s_sen), .ccff_tail(s_chain[SMALL_N-1]), .busy(s_busy), .done(s_done),
    .error(s_error), .chain_len(s_len));

  // Fabric chain models
  always @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      p_chain  <= '0;
      q_chain  <= '0;
      s_chain  <= '0;
      p_ones   <= 0;
      s_shifts <= 0;
    end else begin
      if (p_sen) begin
        p_chain <= {p_chain[BIG_N-2:0], p_head};
        if (p_head) p_ones <= p_ones + 1;
      end
      if (q_sen) q_chain <= {q_chain[SHORT_N-2:0], q_head};
      if (s_sen) begin
        s_chain  <= {s_chain[SMALL_N-2:0], s_head};
        s_shifts <= s_shifts + 1;
      end
    end
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic apply_reset();
    prog_reset = 1'b1;
    b_start = 1'b0; s_start = 1'b0; s_valid = 1'b0; s_word = '0;
    tick(); tick();
    prog_reset = 1'b0;
    tick();
  endtask

  task automatic small_start_load();
    s_test_mode = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    while (!s_ready && t < 200) begin tick(); t++; end
    n_vec++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_word_ready: word_ready=%b required 1", s_ready);
    end
    s_word = w; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; s_word = '0;
  endtask

  task automatic wait_small_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (s_done === 1'b1) begin cyc = i; break; end
    end
  endtask

  task automatic check_small_result(input string tag, input int cyc);
    n_vec++;
    if (cyc < 0) begin n_err++; $display("FAIL %s_done: done never seen, required within 200 cycles", tag); end
    n_vec++;
    if (s_shifts !== SMALL_N) begin n_err++; $display("FAIL %s_shifts: got %0d required %0d", tag, s_shifts, SMALL_N); end
    n_vec++;
    if (s_chain !== EXP_SMALL) begin n_err++; $display("FAIL %s_chain: got %h required %h", tag, s_chain, EXP_SMALL); end
    n_vec++;
    if (s_error !== 1'b0) begin n_err++; $display("FAIL %s_error: got %b required 0", tag, s_error); end
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    int busy_cnt = 0;
    prog_reset = 1'b1;
    #3;
    outs = {s_ready, s_head, s_sen, s_busy, s_done, s_error};
    n_vec++;
    if (outs !== 6'b0 || s_len !== '0) begin
      n_err++; $display("FAIL reset_small_outs: got %b len %0d required 000000 len 0", outs, s_len);
    end
    outs = {p_ready | q_ready | t_ready, p_head | q_head | t_head, p_sen | q_sen | t_sen,
            p_busy | q_busy | t_busy, p_done | q_done | t_done, p_error | q_error | t_error};
    n_vec++;
    if (outs !== 6'b0 || (p_len | q_len | t_len) !== '0) begin
      n_err++; $display("FAIL reset_big_outs: got %b required 000000 with zero chain_len", outs);
    end
    tick();
    prog_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (s_busy !== 1'b0 || p_busy !== 1'b0 || s_sen !== 1'b0) busy_cnt++;
    end
    n_vec++;
    if (busy_cnt !== 0) begin n_err++; $display("FAIL idle_no_start: busy cycles=%0d required 0", busy_cnt); end
  endtask

  task automatic test_chain();
    int p_cyc = -1, q_cyc = -1, t_cyc = -1;
    logic p_e, q_e, t_e;
    logic [BW-1:0] pl, ql, tl;
    apply_reset();
    b_test_mode = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c <= 29800; c++) begin
      tick();
      if (p_done === 1'b1 && p_cyc < 0) begin p_cyc = c; p_e = p_error; pl = p_len; end
      if (q_done === 1'b1 && q_cyc < 0) begin q_cyc = c; q_e = q_error; ql = q_len; end
      if (t_done === 1'b1 && t_cyc < 0) begin t_cyc = c; t_e = t_error; tl = t_len; end
      if (p_cyc >= 0 && q_cyc >= 0 && t_cyc >= 0) break;
    end
    n_vec++;
    if (p_cyc !== BIG_N + 1) begin n_err++; $display("FAIL chain_pass_done_cycle: got %0d required %0d", p_cyc, BIG_N + 1); end
    n_vec++;
    if (p_e !== 1'b0 || pl !== BW'(BIG_N)) begin n_err++; $display("FAIL chain_pass_result: error=%b len=%0d required error=0 len=%0d", p_e, pl, BIG_N); end
    n_vec++;
    if (p_ones !== 1) begin n_err++; $display("FAIL chain_pass_marker: ones on head=%0d required 1", p_ones); end
    n_vec++;
    if (q_cyc !== SHORT_N + 1) begin n_err++; $display("FAIL chain_short_done_cycle: got %0d required %0d", q_cyc, SHORT_N + 1); end
    n_vec++;
    if (q_e !== 1'b1 || ql !== BW'(SHORT_N)) begin n_err++; $display("FAIL chain_short_result: error=%b len=%0d required error=1 len=%0d", q_e, ql, SHORT_N); end
    n_vec++;
    if (t_cyc !== BIG_N + 16 + 1) begin n_err++; $display("FAIL chain_stuck_done_cycle: got %0d required %0d", t_cyc, BIG_N + 17); end
    n_vec++;
    if (t_e !== 1'b1 || tl !== '0) begin n_err++; $display("FAIL chain_stuck_result: error=%b len=%0d required error=1 len=0", t_e, tl); end
    tick();
    tick();
    n_vec++;
    if ({p_busy, p_done, p_error, q_error, t_error} !== 5'b00011) begin
      n_err++; $display("FAIL chain_after: busy,done,perr,qerr,terr=%b required 00011", {p_busy, p_done, p_error, q_error, t_error});
    end
  endtask

  task automatic test_load_partial();
    int cyc;
    apply_reset();
    small_start_load();
    send_word(WORD0);
    send_word(WORD1);
    wait_small_done(cyc);
    check_small_result("load_partial", cyc);
    tick();
    n_vec++;
    if ({s_busy, s_done} !== 2'b00) begin n_err++; $display("FAIL load_idle_after: busy,done=%b required 00", {s_busy, s_done}); end
  endtask

  task automatic test_stall_ignored_start();
    int cyc, bad = 0, t = 0;
    apply_reset();
    small_start_load();
    send_word(WORD0);
    while (!s_ready && t < 100) begin tick(); t++; end
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin s_test_mode = 1'b1; s_start = 1'b1; end
      tick();
      s_start = 1'b0;
      if (s_sen !== 1'b0 || s_ready !== 1'b1) bad++;
    end
    s_test_mode = 1'b0;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL stall_quiet: bad cycles=%0d required 0", bad); end
    n_vec++;
    if (s_shifts !== 32 || s_busy !== 1'b1) begin
      n_err++; $display("FAIL stall_count: shifts=%0d busy=%b required 32 busy=1", s_shifts, s_busy);
    end
    send_word(WORD1);
    wait_small_done(cyc);
    check_small_result("stall", cyc);
  endtask

  task automatic test_reset_mid_shift();
    int cyc, t = 0;
    apply_reset();
    small_start_load();
    send_word(WORD0);
    while (s_shifts < 17 && t < 100) begin tick(); t++; end
    prog_reset = 1'b1;
    #1;
    n_vec++;
    if ({s_sen, s_busy} !== 2'b00) begin n_err++; $display("FAIL midreset_now: shift_en,busy=%b required 00", {s_sen, s_busy}); end
    tick();
    n_vec++;
    if ({s_sen, s_busy, s_ready} !== 3'b000) begin n_err++; $display("FAIL midreset_next: shift_en,busy,ready=%b required 000", {s_sen, s_busy, s_ready}); end
    prog_reset = 1'b0;
    tick();
    small_start_load();
    send_word(WORD0);
    send_word(WORD1);
    wait_small_done(cyc);
    check_small_result("midreset_reload", cyc);
  endtask

  initial begin
    test_reset();
    test_load_partial();
    test_stall_ignored_start();
    test_reset_mid_shift();
    test_chain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
